// File: rtl/cpu_pkg.sv
// cpu_pkg: shared PC width, return-stack state encodings and flag bit positions
package cpu_pkg;
  localparam int PC_WIDTH = 9;
  localparam int FLAG_EMPTY = 0;
  localparam int FLAG_FULL = 1;
  localparam int FLAG_UNDERFLOW = 2;
  localparam int FLAG_OVERFLOW = 3;
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL = 2'd2
  } state_t;
endpackage

// File: rtl/stack_regfile.sv
// stack_regfile: entry array below the top register, one write port, one registered read port with write bypass
module stack_regfile #(
  parameter int DW = 9,
  parameter int N = 15,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [N];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= (i_we && i_waddr == i_raddr) ? i_wdata : r_mem[i_raddr];
  end
endmodule

// File: rtl/return_stack.sv
// return_stack: registered call/return address stack with top register, state FSM and sticky error flags
module return_stack
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = PC_WIDTH,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_push_en,
  input  logic                    in_pop_en,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_clear_errors,
  output logic [DATA_WIDTH-1:0]   out_top,
  output logic [3:0]              out_flags,
  output logic [$clog2(DEPTH):0]  out_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] MAX = CW'(DEPTH);
  state_t r_state, w_state_nx;
  logic [CW-1:0] r_count, w_count_nx;
  logic [DATA_WIDTH-1:0] r_top, w_top_nx, w_below;
  logic r_ovf, r_udf, w_push, w_pop, w_repl, w_ovf, w_udf, w_we;
  logic [AW-1:0] w_waddr, w_raddr;
  stack_regfile #(.DW(DATA_WIDTH), .N(DEPTH - 1), .AW(AW)) u_regfile (
    .clk(clk),
    .i_we(w_we),
    .i_waddr(w_waddr),
    .i_wdata(r_top),
    .i_raddr(w_raddr),
    .o_rdata(w_below)
  );
  always_comb begin
    w_push = in_push_en && (in_pop_en ? r_count == '0 : r_count != MAX);
    w_pop = in_pop_en && !in_push_en && r_count != '0;
    w_repl = in_push_en && in_pop_en && r_count != '0;
    w_ovf = in_push_en && !in_pop_en && r_count == MAX;
    w_udf = in_pop_en && r_count == '0;
    w_count_nx = w_push ? r_count + 1'b1 : w_pop ? r_count - 1'b1 : r_count;
    w_top_nx = (w_push || w_repl) ? in_data : w_pop ? (r_count == CW'(1) ? '0 : w_below) : r_top;
    w_state_nx = w_count_nx == '0 ? S_EMPTY : w_count_nx == MAX ? S_FULL : S_PARTIAL;
    w_we = rst_n && w_push && r_count != '0;
    w_waddr = AW'(r_count - 1'b1);
    w_raddr = w_count_nx > CW'(1) ? AW'(w_count_nx - CW'(2)) : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_count <= '0;
      r_top <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_count <= w_count_nx;
      r_top <= w_top_nx;
      r_ovf <= w_ovf || (r_ovf && !in_clear_errors);
      r_udf <= w_udf || (r_udf && !in_clear_errors);
    end
  end
  always_comb begin
    out_flags = '0;
    out_flags[FLAG_EMPTY] = r_state == S_EMPTY;
    out_flags[FLAG_FULL] = r_state == S_FULL;
    out_flags[FLAG_UNDERFLOW] = r_udf;
    out_flags[FLAG_OVERFLOW] = r_ovf;
  end
  assign out_top = r_top;
  assign out_count = r_count;
endmodule

// File: tb/tb_return_stack.sv
// tb_return_stack: directed self-checking bench for return_stack
module tb_return_stack;
  logic clk = 1'b0;
  logic rst_n, in_push_en, in_pop_en, in_clear_errors;
  logic [8:0] in_data, out_top;
  logic [3:0] out_flags;
  logic [4:0] out_count;
  logic [8:0] vals [16];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  return_stack #(.DATA_WIDTH(9), .DEPTH(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_push_en(in_push_en),
    .in_pop_en(in_pop_en),
    .in_data(in_data),
    .in_clear_errors(in_clear_errors),
    .out_top(out_top),
    .out_flags(out_flags),
    .out_count(out_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic op(input logic rn, input logic pu, input logic po, input logic cl, input logic [8:0] d);
    rst_n = rn;
    in_push_en = pu;
    in_pop_en = po;
    in_clear_errors = cl;
    in_data = d;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_push_en = 1'b0;
    in_pop_en = 1'b0;
    in_clear_errors = 1'b0;
  endtask
  task automatic expect3(input string tag, input logic [8:0] top, input logic [4:0] cnt, input logic [3:0] fl);
    chk({tag, "_top"}, 32'(out_top), 32'(top));
    chk({tag, "_cnt"}, 32'(out_count), 32'(cnt));
    chk({tag, "_flags"}, 32'(out_flags), 32'(fl));
  endtask
  initial begin
    rst_n = 1'b0;
    in_push_en = 1'b0;
    in_pop_en = 1'b0;
    in_clear_errors = 1'b0;
    in_data = '0;
    for (int i = 0; i < 16; i++) vals[i] = 9'(9'h100 + 9'(i * 5));
    op(1'b0, 1'b0, 1'b0, 1'b0, '0);
    op(1'b0, 1'b0, 1'b0, 1'b0, '0);
    expect3("reset", 9'h000, 5'd0, 4'b0001);
    op(1'b1, 1'b1, 1'b0, 1'b0, 9'h1F0);
    expect3("push1", 9'h1F0, 5'd1, 4'b0000);
    op(1'b1, 1'b1, 1'b0, 1'b0, 9'h1E1);
    expect3("push2", 9'h1E1, 5'd2, 4'b0000);
    op(1'b1, 1'b1, 1'b0, 1'b0, 9'h003);
    expect3("push3", 9'h003, 5'd3, 4'b0000);
    op(1'b1, 1'b0, 1'b1, 1'b0, '0);
    expect3("pop1", 9'h1E1, 5'd2, 4'b0000);
    op(1'b1, 1'b0, 1'b1, 1'b0, '0);
    expect3("pop2", 9'h1F0, 5'd1, 4'b0000);
    op(1'b1, 1'b0, 1'b1, 1'b0, '0);
    expect3("pop3", 9'h000, 5'd0, 4'b0001);
    for (int i = 0; i < 16; i++) op(1'b1, 1'b1, 1'b0, 1'b0, vals[i]);
    expect3("fill16", vals[15], 5'd16, 4'b0010);
    op(1'b1, 1'b1, 1'b0, 1'b0, 9'h0AA);
    expect3("push17", vals[15], 5'd16, 4'b1010);
    op(1'b1, 1'b0, 1'b0, 1'b1, '0);
    expect3("clr_ovf", vals[15], 5'd16, 4'b0010);
    op(1'b1, 1'b1, 1'b1, 1'b0, 9'h155);
    expect3("repl_full", 9'h155, 5'd16, 4'b0010);
    op(1'b1, 1'b0, 1'b1, 1'b0, '0);
    expect3("pop_full", vals[14], 5'd15, 4'b0000);
    op(1'b1, 1'b0, 1'b1, 1'b0, '0);
    expect3("pop_15", vals[13], 5'd14, 4'b0000);
    op(1'b0, 1'b0, 1'b0, 1'b0, '0);
    expect3("reset2", 9'h000, 5'd0, 4'b0001);
    op(1'b1, 1'b0, 1'b1, 1'b0, '0);
    expect3("pop_empty", 9'h000, 5'd0, 4'b0101);
    op(1'b1, 1'b0, 1'b0, 1'b1, '0);
    expect3("clr_udf", 9'h000, 5'd0, 4'b0001);
    op(1'b1, 1'b0, 1'b1, 1'b1, '0);
    expect3("clr_vs_err", 9'h000, 5'd0, 4'b0101);
    op(1'b1, 1'b0, 1'b0, 1'b1, '0);
    op(1'b1, 1'b1, 1'b1, 1'b0, 9'h0C3);
    expect3("pushpop_empty", 9'h0C3, 5'd1, 4'b0100);
    op(1'b1, 1'b0, 1'b0, 1'b1, '0);
    op(1'b1, 1'b1, 1'b0, 1'b0, 9'h011);
    op(1'b1, 1'b1, 1'b0, 1'b0, 9'h022);
    expect3("cnt3", 9'h022, 5'd3, 4'b0000);
    op(1'b1, 1'b1, 1'b1, 1'b0, 9'h155);
    expect3("repl3", 9'h155, 5'd3, 4'b0000);
    op(1'b1, 1'b0, 1'b1, 1'b0, '0);
    expect3("pop_after_repl", 9'h011, 5'd2, 4'b0000);
    op(1'b1, 1'b0, 1'b1, 1'b0, '0);
    expect3("pop_to_1", 9'h0C3, 5'd1, 4'b0000);
    op(1'b1, 1'b1, 1'b0, 1'b0, 9'h077);
    op(1'b1, 1'b1, 1'b0, 1'b0, 9'h088);
    expect3("pre_rst", 9'h088, 5'd3, 4'b0000);
    op(1'b0, 1'b1, 1'b0, 1'b0, 9'h099);
    expect3("rst_push", 9'h000, 5'd0, 4'b0001);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
